// File: rtl/register_file_pc.sv
// ============================================================================
// Module   : register_file_pc
// Purpose  : Multi-ported register file whose top register doubles as a
//            program counter. One write port, three registered read ports
//            with write-first (post-edge) read semantics, and a PC that can
//            be loaded, written through the general port, or incremented.
// Ports    :
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset
//   we, wa, wd          general write port
//   re                  read enable, captures all three read ports
//   ra_a, ra_b, ra_c    read addresses
//   rd_a, rd_b, rd_c    registered read data
//   rd_valid            read data valid (one cycle after a re=1 edge)
//   pc_ld, pc_in        PC load
//   pc_en               PC increment by PC_INC
//   pc_out              current PC, straight from the PC register
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file_pc #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int PC_INC     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] ra_a,
  input  logic [ADDR_WIDTH-1:0] ra_b,
  input  logic [ADDR_WIDTH-1:0] ra_c,
  output logic [DATA_WIDTH-1:0] rd_a,
  output logic [DATA_WIDTH-1:0] rd_b,
  output logic [DATA_WIDTH-1:0] rd_c,
  output logic                  rd_valid,
  input  logic                  pc_ld,
  input  logic [DATA_WIDTH-1:0] pc_in,
  input  logic                  pc_en,
  output logic [DATA_WIDTH-1:0] pc_out
);

  localparam int                    NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PC_ADDR  = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [DATA_WIDTH-1:0] PC_STEP  = DATA_WIDTH'(PC_INC);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic [DATA_WIDTH-1:0] rd_a_q, rd_a_d;
  logic [DATA_WIDTH-1:0] rd_b_q, rd_b_d;
  logic [DATA_WIDTH-1:0] rd_c_q, rd_c_d;
  logic                  rd_valid_q, rd_valid_d;

  // Next-state of the whole register file. The read ports below sample this
  // next-state array, which is what makes reads write-first: same-edge writes,
  // loads and increments are visible in the captured data.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end

    // General registers: the PC address is excluded so the PC priority
    // chain below fully owns the top register.
    if (we && (wa != PC_ADDR)) begin
      regs_d[wa] = wd;
    end

    // PC priority: load > general write > increment > hold.
    // A load that collides with a general write to the PC drops wd entirely.
    if (pc_ld) begin
      regs_d[NUM_REGS-1] = pc_in;
    end else if (we && (wa == PC_ADDR)) begin
      regs_d[NUM_REGS-1] = wd;
    end else if (pc_en) begin
      regs_d[NUM_REGS-1] = regs_q[NUM_REGS-1] + PC_STEP;  // wraps silently
    end
  end

  always_comb begin
    rd_a_d     = rd_a_q;
    rd_b_d     = rd_b_q;
    rd_c_d     = rd_c_q;
    rd_valid_d = re;
    if (re) begin
      rd_a_d = regs_d[ra_a];
      rd_b_d = regs_d[ra_b];
      rd_c_d = regs_d[ra_c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      rd_a_q     <= '0;
      rd_b_q     <= '0;
      rd_c_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      rd_a_q     <= rd_a_d;
      rd_b_q     <= rd_b_d;
      rd_c_q     <= rd_c_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_a     = rd_a_q;
  assign rd_b     = rd_b_q;
  assign rd_c     = rd_c_q;
  assign rd_valid = rd_valid_q;
  assign pc_out   = regs_q[NUM_REGS-1];

endmodule

`default_nettype wire

// File: tb/tb_register_file_pc.sv
// ============================================================================
// Module   : tb_register_file_pc
// Purpose  : Self-checking bench for register_file_pc. Read expectations are
//            queued when a read is issued; a monitor pops and compares them
//            whenever rd_valid is seen. PC and hold behaviour are checked
//            directly against hand-computed constants.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_file_pc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [3:0]  wa;
  logic [31:0] wd;
  logic        re;
  logic [3:0]  ra_a, ra_b, ra_c;
  logic [31:0] rd_a, rd_b, rd_c;
  logic        rd_valid;
  logic        pc_ld;
  logic [31:0] pc_in;
  logic        pc_en;
  logic [31:0] pc_out;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  register_file_pc dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .re       (re),
    .ra_a     (ra_a),
    .ra_b     (ra_b),
    .ra_c     (ra_c),
    .rd_a     (rd_a),
    .rd_b     (rd_b),
    .rd_c     (rd_c),
    .rd_valid (rd_valid),
    .pc_ld    (pc_ld),
    .pc_in    (pc_in),
    .pc_en    (pc_en),
    .pc_out   (pc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    exp_t e;
    e.a = a;
    e.b = b;
    e.c = c;
    exp_q.push_back(e);
  endtask

  // Samples on the falling edge, well away from the active edge.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rd_valid", 32'(rd_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rd_a", rd_a, e.a);
          chk("rd_b", rd_b, e.b);
          chk("rd_c", rd_c, e.c);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    we = 1'b0; wa = '0; wd = '0;
    re = 1'b0; ra_a = '0; ra_b = '0; ra_c = '0;
    pc_ld = 1'b0; pc_in = '0; pc_en = 1'b0;

    fork
      monitor();
    join_none

    repeat (2) tick();
    chk("reset_pc_out", pc_out, 32'h0);
    chk("reset_rd_valid", 32'(rd_valid), 32'h0);
    chk("reset_rd_a", rd_a, 32'h0);

    // First edge after reset release: read zeros from r0, r5, PC.
    rst_n = 1'b1;
    re = 1'b1; ra_a = 4'd0; ra_b = 4'd5; ra_c = 4'd15;
    push(32'h0, 32'h0, 32'h0);
    tick();
    re = 1'b0;

    // Write-first bypass on the same edge; two ports on the same register.
    we = 1'b1; wa = 4'd3; wd = 32'hDEADBEEF;
    re = 1'b1; ra_a = 4'd3; ra_b = 4'd3; ra_c = 4'd4;
    push(32'hDEADBEEF, 32'hDEADBEEF, 32'h0);
    tick();
    re = 1'b0;

    wa = 4'd4; wd = 32'h12345678; tick();
    wa = 4'd0; wd = 32'hA5A5A5A5; tick();
    we = 1'b0;

    re = 1'b1; ra_a = 4'd0; ra_b = 4'd4; ra_c = 4'd3;
    push(32'hA5A5A5A5, 32'h12345678, 32'hDEADBEEF);
    tick();
    re = 1'b0;

    // Two idle cycles: outputs hold, valid drops.
    repeat (2) tick();
    chk("hold_rd_valid", 32'(rd_valid), 32'h0);
    chk("hold_rd_a", rd_a, 32'hA5A5A5A5);
    chk("hold_rd_b", rd_b, 32'h12345678);
    chk("hold_rd_c", rd_c, 32'hDEADBEEF);

    // PC load then increments across the 32-bit wrap.
    pc_ld = 1'b1; pc_in = 32'hFFFFFFF8; tick();
    chk("pc_load", pc_out, 32'hFFFFFFF8);
    pc_ld = 1'b0; pc_en = 1'b1;
    tick(); chk("pc_inc1", pc_out, 32'hFFFFFFFC);
    tick(); chk("pc_inc_wrap", pc_out, 32'h00000000);
    // Read the PC on the same edge as its increment: sees the new value.
    re = 1'b1; ra_a = 4'd0; ra_b = 4'd4; ra_c = 4'd15;
    push(32'hA5A5A5A5, 32'h12345678, 32'h00000004);
    tick(); chk("pc_inc3", pc_out, 32'h00000004);
    re = 1'b0; pc_en = 1'b0;
    tick(); chk("pc_hold", pc_out, 32'h00000004);

    // Load beats general write to PC and increment; wd lands nowhere.
    pc_ld = 1'b1; pc_in = 32'h100; we = 1'b1; wa = 4'd15; wd = 32'h200; pc_en = 1'b1;
    tick();
    chk("pc_ld_priority", pc_out, 32'h100);
    pc_ld = 1'b0; we = 1'b0; pc_en = 1'b0;
    re = 1'b1; ra_a = 4'd3; ra_b = 4'd15; ra_c = 4'd0;
    push(32'hDEADBEEF, 32'h100, 32'hA5A5A5A5);
    tick();
    re = 1'b0;

    // General write to PC beats increment.
    we = 1'b1; wa = 4'd15; wd = 32'h3000; pc_en = 1'b1;
    tick();
    chk("pc_we_priority", pc_out, 32'h3000);
    pc_en = 1'b0;

    // Write r7, read it, then reset asynchronously mid-cycle.
    wa = 4'd7; wd = 32'h55; tick();
    we = 1'b0;
    re = 1'b1; ra_a = 4'd7; ra_b = 4'd7; ra_c = 4'd7;
    tick();
    re = 1'b0;
    chk("pre_reset_rd_a", rd_a, 32'h55);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rd_a", rd_a, 32'h0);
    chk("async_rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("async_rst_pc_out", pc_out, 32'h0);

    // Activity during reset is ignored.
    @(posedge clk); #1;
    we = 1'b1; wa = 4'd7; wd = 32'h99; pc_en = 1'b1; re = 1'b1;
    tick();
    chk("in_reset_pc_out", pc_out, 32'h0);
    chk("in_reset_rd_valid", 32'(rd_valid), 32'h0);

    // Release; first edge reads r7, PC, r3 -- all cleared.
    rst_n = 1'b1;
    we = 1'b0; pc_en = 1'b0;
    re = 1'b1; ra_a = 4'd7; ra_b = 4'd15; ra_c = 4'd3;
    push(32'h0, 32'h0, 32'h0);
    tick();
    re = 1'b0;
    repeat (3) tick();

    chk("pending_reads_left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/register_file_pc.md
REGISTER_FILE_PC -- requirements
Module: register_file_pc

Interface
REQ-001: Parameter DATA_WIDTH, default 32, SHALL set the width of every register, write-data, read-data and PC bus.
REQ-002: Parameter ADDR_WIDTH, default 4, SHALL set the register-address width; NUM_REGS = 2**ADDR_WIDTH, with register NUM_REGS-1 as the PC.
REQ-003: Parameter PC_INC, default 4, SHALL set the PC increment step.
REQ-004: The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005: clk  input  1  rising-edge clock.
REQ-006: rst_n  input  1  asynchronous active-low reset.
REQ-007: we  input  1  write enable for the general write port.
REQ-008: wa  input  ADDR_WIDTH  write address.
REQ-009: wd  input  DATA_WIDTH  write data.
REQ-010: re  input  1  read enable, capturing all three read ports.
REQ-011: ra_a, ra_b, ra_c  input  ADDR_WIDTH each  read addresses.
REQ-012: rd_a, rd_b, rd_c  output  DATA_WIDTH each  registered read data.
REQ-013: rd_valid  output  1  read data valid.
REQ-014: pc_ld  input  1  load PC from pc_in.
REQ-015: pc_in  input  DATA_WIDTH  PC load value.
REQ-016: pc_en  input  1  increment PC by PC_INC.
REQ-017: pc_out  output  DATA_WIDTH  current PC, driven directly from the PC register.

Function
REQ-018: General registers 0..NUM_REGS-2 SHALL update only at the rising clk edge, and only when we=1 and wa addresses them.
REQ-019: The PC next value SHALL follow fixed priority: pc_ld=1 -> pc_in; else we=1 and wa=NUM_REGS-1 -> wd; else pc_en=1 -> PC+PC_INC; else hold.
REQ-020: PC increment SHALL wrap modulo 2**DATA_WIDTH with no flag (e.g. DATA_WIDTH=32: 0xFFFFFFFC+4 -> 0x00000000).
REQ-021: Read latency SHALL be one cycle: with re=1 at edge N, rd_a/rd_b/rd_c SHALL present data at edge N and rd_valid SHALL be 1 for the following cycle.
REQ-022: Read semantics SHALL be write-first: each rd_x SHALL capture the value its addressed register holds after edge N, including same-edge writes and PC load/increment.
REQ-023: When re=0 at an edge, rd_a/rd_b/rd_c SHALL hold their previous values and rd_valid SHALL be 0.
REQ-024: Multiple read ports addressing the same register SHALL return identical data.
REQ-025: A cycle with pc_ld=1 and we=1, wa=PC SHALL apply pc_in; wd SHALL be discarded with no side effect on other registers.
REQ-026: Inputs SHALL have no combinational path to any output.

Reset
REQ-027: rst_n=0 SHALL immediately, without a clock, clear all NUM_REGS registers, pc_out, rd_a, rd_b, rd_c to 0 and rd_valid to 0.
REQ-028: While rst_n=0, writes, loads, increments and reads SHALL be ignored.
REQ-029: Reset assertion mid-operation, including the cycle after a read, SHALL discard pending read data; rd_valid SHALL be 0 until a new re=1 edge after deassertion.
REQ-030: The first edge after rst_n rises SHALL be fully functional.

Verification
REQ-031: Reset, then re=1, ra_a=0, ra_b=5, ra_c=15 -> next cycle rd_a=rd_b=rd_c=0, rd_valid=1.
REQ-032: we=1, wa=3, wd=0xDEADBEEF with re=1, ra_a=3 on the same edge -> rd_a=0xDEADBEEF, rd_valid=1 after that edge (write-first bypass).
REQ-033: pc_ld=1, pc_in=0xFFFFFFF8, then pc_en=1 for three cycles -> pc_out 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
REQ-034: pc_ld=1, pc_in=0x100, we=1, wa=15, wd=0x200, pc_en=1 on one edge -> pc_out=0x100; then re=1, ra_b=15 -> rd_b=0x100.
REQ-035: Write r7=0x55, then read r7, then assert rst_n=0 asynchronously mid-cycle -> rd_a=0 and rd_valid=0 immediately, r7 reads 0 after reset.
REQ-036: re=0 for two cycles following a valid read -> rd_valid=0, rd_a/rd_b/rd_c unchanged.
